// File: rtl/apb_sl_bridge_mc_if.sv
// APB bus bundle between the system interconnect and the SL bridge.
//   paddr/psel/penable/pwrite/pwdata : master -> slave request
//   prdata/pready/pslverr            : slave -> master response
interface apb_sl_bridge_mc_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_sl_bridge_mc.sv
// APB register bank serving NUM_CH SL transceiver cores in one clock domain.
// Per channel (base n*0x10): CONFIG 0x0, STATUS 0x4 (sticky W1C), TXDATA 0x8,
// RXDATA 0xC (read pops the RX FIFO).
// Ports:
//   clk, rst_n      : system clock, async active-low reset
//   apb             : APB slave bus (zero wait states, combinational response)
//   cfg             : per-channel config, channel n at [n*CFG_W +: CFG_W]
//   tx_data/valid   : TX holding register towards the SL core, tx_ready accepts
//   rx_valid/data   : one-cycle receive strobe and word from the SL core
//   rx_err          : {length, level, parity} error flags with rx_valid
//   irq             : per-channel registered level interrupt
module apb_sl_bridge_mc #(
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 32,
  parameter int CFG_W      = 16,
  parameter int ADDR_W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  apb_sl_bridge_mc_if.slave        apb,
  output logic [NUM_CH*CFG_W-1:0]  cfg,
  output logic [NUM_CH*DATA_W-1:0] tx_data,
  output logic [NUM_CH-1:0]        tx_valid,
  input  logic [NUM_CH-1:0]        tx_ready,
  input  logic [NUM_CH-1:0]        rx_valid,
  input  logic [NUM_CH*DATA_W-1:0] rx_data,
  input  logic [NUM_CH*3-1:0]      rx_err,
  output logic [NUM_CH-1:0]        irq
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CH_W  = ADDR_W - 4;

  logic              access;
  logic [CH_W-1:0]   ch_idx;
  logic [1:0]        off;
  logic [1:0]        unused_addr_lo;
  logic [NUM_CH-1:0] ch_sel;
  logic [NUM_CH-1:0] ch_err;
  logic [DATA_W-1:0] ch_rdata [NUM_CH];
  logic [DATA_W-1:0] rdata_mux;

  assign access         = apb.psel & apb.penable;
  assign ch_idx         = apb.paddr[ADDR_W-1:4];
  assign off            = apb.paddr[3:2];
  assign unused_addr_lo = apb.paddr[1:0];

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic [CFG_W-1:0]  cfg_q;
    logic [DATA_W-1:0] tx_data_q;
    logic              tx_valid_q;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        sticky_q, sticky_d;  // {wle, lef, pef, ovf}
    logic              irq_q;
    logic              wr_cfg, wr_sts, wr_tx, pop, push_ok, full, empty;
    logic [2:0]        err_in;
    logic [DATA_W-1:0] sts;
    logic [DATA_W-1:0] rdata;
    logic              err;

    assign ch_sel[n] = access && (ch_idx == CH_W'(n));
    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign wr_cfg    = ch_sel[n] & apb.pwrite & (off == 2'd0);
    assign wr_sts    = ch_sel[n] & apb.pwrite & (off == 2'd1);
    assign wr_tx     = ch_sel[n] & apb.pwrite & (off == 2'd2) & ~tx_valid_q;
    assign pop       = ch_sel[n] & ~apb.pwrite & (off == 2'd3) & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok   = rx_valid[n] & (~full | pop);
    assign err_in    = rx_valid[n] ? rx_err[n*3 +: 3] : 3'b000;

    always_comb begin
      cnt_d = cnt_q;
      if (push_ok && !pop)      cnt_d = cnt_q + 1'b1;
      else if (pop && !push_ok) cnt_d = cnt_q - 1'b1;
      // Clear first, then set: a same-cycle set event wins over W1C.
      sticky_d = sticky_q;
      if (wr_sts) sticky_d = sticky_q & ~apb.pwdata[6:3];
      sticky_d = sticky_d | {err_in, rx_valid[n] & full & ~pop};
    end

    always_comb begin
      sts       = '0;
      sts[0]    = tx_valid_q;
      sts[1]    = ~empty;
      sts[2]    = full;
      sts[6:3]  = sticky_q;
      sts[15:8] = 8'(cnt_q);
    end

    always_comb begin
      rdata = '0;
      err   = 1'b0;
      if (ch_sel[n]) begin
        case (off)
          2'd0: if (!apb.pwrite) rdata = DATA_W'(cfg_q);
          2'd1: if (!apb.pwrite) rdata = sts;
          2'd2: err = apb.pwrite & tx_valid_q;
          default: begin
            if (apb.pwrite || empty) err = 1'b1;
            else                     rdata = mem_q[rd_ptr_q];
          end
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cfg_q      <= '0;
        tx_data_q  <= '0;
        tx_valid_q <= 1'b0;
        rd_ptr_q   <= '0;
        wr_ptr_q   <= '0;
        cnt_q      <= '0;
        sticky_q   <= '0;
        irq_q      <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        sticky_q <= sticky_d;
        irq_q    <= cfg_q[8] & (~empty | (|sticky_q));
        if (wr_cfg) cfg_q <= apb.pwdata[CFG_W-1:0];
        if (wr_tx) begin
          tx_data_q  <= apb.pwdata;
          tx_valid_q <= 1'b1;
        end else if (tx_valid_q && tx_ready[n]) begin
          tx_valid_q <= 1'b0;
        end
        if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= rx_data[n*DATA_W +: DATA_W];
    end

    assign ch_rdata[n]               = rdata;
    assign ch_err[n]                 = err;
    assign cfg[n*CFG_W +: CFG_W]     = cfg_q;
    assign tx_data[n*DATA_W +: DATA_W] = tx_data_q;
    assign tx_valid[n]               = tx_valid_q;
    assign irq[n]                    = irq_q;
  end

  // Per-channel read data is already zero unless that channel is selected.
  always_comb begin
    rdata_mux = '0;
    for (int n = 0; n < NUM_CH; n++) rdata_mux = rdata_mux | ch_rdata[n];
  end

  assign apb.prdata  = rdata_mux;
  assign apb.pslverr = access & (~(|ch_sel) | (|ch_err));
  assign apb.pready  = 1'b1;
endmodule
